// File: rtl/trdb_packet_scheduler.sv
// trdb_packet_scheduler: turns sticky trace packet requests into held, prioritised emitter offers
// with a forced start-sync after a programmable number of accepted non-sync packets.
module trdb_packet_scheduler #(
   parameter int RESYNC_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                exc_req_i,
   input  logic                bmap_full_i,
   input  logic                updiscon_req_i,
   input  logic [RESYNC_W-1:0] resync_max_i,
   input  logic                emit_ready_i,
   output logic                emit_valid_o,
   output logic [1:0]          packet_format_o,
   output logic [1:0]          packet_subformat_o,
   output logic                bmap_flush_o,
   output logic                resync_pend_o
);
   typedef enum logic {IDLE, OFFER} state_e;
   localparam logic [1:0] F_SYNC = 2'b11, F_ADDR_ONLY = 2'b10, F_BRANCH_FULL = 2'b01;
   localparam logic [1:0] SF_START = 2'b00, SF_EXCEPTION = 2'b01;
   state_e state;
   logic exc_q, start_q, bmap_q, addr_q;
   logic [RESYNC_W-1:0] cnt_q;
   logic acc, acc_sync, acc_exc, acc_bmap, resync_hit;
   logic exc_d, start_d, bmap_d, addr_d, any_d;
   logic [1:0] fmt_d, sf_d;
   assign emit_valid_o  = state == OFFER;
   assign resync_pend_o = start_q;
   // every packet kind serves the addr request, so any acceptance clears it
   always_comb begin
      acc        = emit_valid_o & emit_ready_i;
      acc_sync   = acc & (packet_format_o == F_SYNC);
      acc_exc    = acc_sync & (packet_subformat_o == SF_EXCEPTION);
      acc_bmap   = acc & (packet_format_o == F_BRANCH_FULL);
      resync_hit = (resync_max_i != '0) & (cnt_q >= resync_max_i) & ~acc_sync;
      exc_d      = (exc_q & ~acc_exc) | exc_req_i;
      start_d    = (start_q & ~acc_sync) | resync_hit;
      bmap_d     = (bmap_q & ~acc_sync & ~acc_bmap) | bmap_full_i;
      addr_d     = (addr_q & ~acc) | updiscon_req_i;
      any_d      = exc_d | start_d | bmap_d | addr_d;
      fmt_d      = (exc_d | start_d) ? F_SYNC : bmap_d ? F_BRANCH_FULL : addr_d ? F_ADDR_ONLY : 2'b00;
      sf_d       = exc_d ? SF_EXCEPTION : SF_START;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state              <= IDLE;
         packet_format_o    <= 2'b00;
         packet_subformat_o <= 2'b00;
         bmap_flush_o       <= 1'b0;
         cnt_q              <= '0;
         exc_q              <= 1'b0;
         start_q            <= 1'b1;
         bmap_q             <= 1'b0;
         addr_q             <= 1'b0;
      end else begin
         exc_q        <= exc_d;
         start_q      <= start_d;
         bmap_q       <= bmap_d;
         addr_q       <= addr_d;
         bmap_flush_o <= acc_sync | acc_bmap;
         if (acc) cnt_q <= acc_sync ? '0 : (&cnt_q ? cnt_q : cnt_q + RESYNC_W'(1));
         if (state == IDLE || acc) begin
            state              <= any_d ? OFFER : IDLE;
            packet_format_o    <= fmt_d;
            packet_subformat_o <= sf_d;
         end
      end
   end
endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// tb_trdb_packet_scheduler: randomized and directed stimulus checked every cycle against a
// request-queue model of the scheduler, plus literal expectations for the directed scenarios.
module tb_trdb_packet_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic exc = 1'b0, bmap = 1'b0, upd = 1'b0, ready = 1'b0;
   logic [15:0] rmax = 16'd0;
   logic valid, flush, pend;
   logic [1:0] fmt, sf;
   int vectors = 0, errors = 0;

   trdb_packet_scheduler dut (
      .clk_i(clk), .rst_ni(rst_n), .exc_req_i(exc), .bmap_full_i(bmap), .updiscon_req_i(upd),
      .resync_max_i(rmax), .emit_ready_i(ready), .emit_valid_o(valid), .packet_format_o(fmt),
      .packet_subformat_o(sf), .bmap_flush_o(flush), .resync_pend_o(pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: kinds ranked 0=exc 1=start 2=bmap 3=addr; serving kind k satisfies every kind >= k
   bit pq[4];
   bit m_valid, m_flush, m_acc, m_hit;
   int m_kind, m_cnt;

   function automatic logic [1:0] fmt_of(input int k);
      return (k <= 1) ? 2'b11 : (k == 2) ? 2'b01 : 2'b10;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq = '{0, 1, 0, 0};
         m_valid = 0; m_flush = 0; m_kind = 0; m_cnt = 0;
      end else begin
         m_acc = m_valid && ready;
         m_hit = rmax != 0 && m_cnt >= int'(rmax) && !(m_acc && m_kind <= 1);
         m_flush = m_acc && m_kind <= 2;
         if (m_acc) begin
            for (int j = m_kind; j < 4; j++) pq[j] = 0;
            m_cnt = (m_kind <= 1) ? 0 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
         end
         if (exc) pq[0] = 1;
         if (m_hit) pq[1] = 1;
         if (bmap) pq[2] = 1;
         if (upd) pq[3] = 1;
         if (!m_valid || m_acc) begin
            m_valid = 0;
            for (int j = 3; j >= 0; j--) if (pq[j]) begin m_valid = 1; m_kind = j; end
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", valid, m_valid);
      if (m_valid) begin
         chk("format", fmt, fmt_of(m_kind));
         chk("subformat", sf, (m_kind == 0) ? 2'b01 : 2'b00);
      end
      chk("flush", flush, m_flush);
      chk("resync_pend", pend, pq[1]);
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      ready = 1'b1;
      cyc(2);
      chk("rst valid", valid, 1'b0);
      chk("rst format", fmt, 2'b00);
      chk("rst subformat", sf, 2'b00);
      chk("rst flush", flush, 1'b0);
      chk("rst pend", pend, 1'b1);
      rst_n = 1'b1;
      cyc();
      chk("first valid", valid, 1'b1);
      chk("first format", fmt, 2'b11);
      chk("first subformat", sf, 2'b00);
      cyc();
      chk("first flush", flush, 1'b1);
      chk("first idle", valid, 1'b0);
      // branch-full held while an exception arrives
      ready = 1'b0; bmap = 1'b1;
      cyc(); bmap = 1'b0;
      cyc(); exc = 1'b1;
      cyc(); exc = 1'b0;
      chk("held valid", valid, 1'b1);
      chk("held format", fmt, 2'b01);
      cyc();
      chk("still held format", fmt, 2'b01);
      ready = 1'b1;
      cyc();
      chk("exc after bmap format", fmt, 2'b11);
      chk("exc after bmap subformat", sf, 2'b01);
      chk("bmap flush", flush, 1'b1);
      cyc();
      chk("after exc idle", valid, 1'b0);
      // exception swallows a simultaneous address request
      exc = 1'b1; upd = 1'b1;
      cyc(); exc = 1'b0; upd = 1'b0;
      chk("exc+addr format", fmt, 2'b11);
      chk("exc+addr subformat", sf, 2'b01);
      cyc();
      chk("no addr after exc", valid, 1'b0);
      cyc(2);
      chk("still no addr", valid, 1'b0);
      // forced resync every 3 accepted address packets
      rmax = 16'd3;
      for (int i = 0; i < 8; i++) begin
         upd = 1'b1;
         cyc(); upd = 1'b0;
         chk("resync offer", valid, 1'b1);
         chk("resync format", fmt, (i % 4 == 3) ? 2'b11 : 2'b10);
         chk("resync pend", pend, (i % 4 == 3) ? 1'b1 : 1'b0);
         cyc();
         chk("resync idle", valid, 1'b0);
      end
      // random traffic
      for (int c = 0; c < 1500; c++) begin
         exc = ($urandom % 12) == 0;
         bmap = ($urandom % 8) == 0;
         upd = ($urandom % 5) == 0;
         ready = ($urandom % 3) != 0;
         if (c % 200 == 0) rmax = 16'($urandom_range(0, 5));
         cyc();
      end
      exc = 1'b0; bmap = 1'b0; upd = 1'b0; ready = 1'b1; rmax = 16'd0;
      cyc(20);
      chk("drained", valid, 1'b0);
      // counter saturation with resync disabled
      upd = 1'b1;
      cyc(70000);
      upd = 1'b0;
      cyc();
      chk("sat idle", valid, 1'b0);
      rmax = 16'hFFFF;
      cyc();
      chk("sat sync valid", valid, 1'b1);
      chk("sat sync format", fmt, 2'b11);
      chk("sat sync subformat", sf, 2'b00);
      rmax = 16'd0;
      cyc(3);
      // reset in the middle of a held address offer
      ready = 1'b0; upd = 1'b1;
      cyc(); upd = 1'b0;
      chk("pre-reset format", fmt, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("async valid drop", valid, 1'b0);
      chk("async format", fmt, 2'b00);
      chk("async pend", pend, 1'b1);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post-reset valid", valid, 1'b1);
      chk("post-reset format", fmt, 2'b11);
      chk("post-reset subformat", sf, 2'b00);
      ready = 1'b1;
      cyc(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/trdb_packet_scheduler.md
TRDB_PACKET_SCHEDULER -- requirements
Module: trdb_packet_scheduler

Interface
REQ-001 The block SHALL have parameter RESYNC_W, default 16, meaning the width of the resync packet counter and threshold.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port exc_req_i, input, 1 bit: one-cycle pulse requesting an exception sync packet.
REQ-005 The block SHALL have port bmap_full_i, input, 1 bit: one-cycle pulse indicating the branch map is full.
REQ-006 The block SHALL have port updiscon_req_i, input, 1 bit: one-cycle pulse requesting an address-only packet.
REQ-007 The block SHALL have port resync_max_i, input, RESYNC_W bits: number of accepted packets between forced resyncs; 0 disables.
REQ-008 The block SHALL have port emit_ready_i, input, 1 bit: the packet emitter accepts the offered packet.
REQ-009 The block SHALL have port emit_valid_o, output, 1 bit: a packet request is offered to the emitter.
REQ-010 The block SHALL have port packet_format_o, output, 2 bits: trdb_format_e; 2'b11 F_SYNC, 2'b10 F_ADDR_ONLY, 2'b01 F_BRANCH_FULL.
REQ-011 The block SHALL have port packet_subformat_o, output, 2 bits: 2'b00 SF_START, 2'b01 SF_EXCEPTION; 2'b00 unless format is F_SYNC.
REQ-012 The block SHALL have port bmap_flush_o, output, 1 bit: one-cycle pulse on acceptance of any packet that carries the branch map.
REQ-013 The block SHALL have port resync_pend_o, output, 1 bit: a forced resync is pending.

Function
REQ-014 Each request pulse SHALL set a sticky pending flag (exc, start, bmap, addr) cleared only when a packet serving it is accepted.
REQ-015 States SHALL be IDLE and OFFER; IDLE -> OFFER when any flag is pending, with the format chosen on that edge.
REQ-016 In OFFER, emit_valid_o=1, and format/subformat SHALL be held stable until emit_valid_o && emit_ready_i (acceptance).
REQ-017 On acceptance: if flags remain pending (including ones set that cycle), stay in OFFER with the next choice; else go to IDLE.
REQ-018 Priority SHALL be exc (F_SYNC/SF_EXCEPTION) > start (F_SYNC/SF_START) > bmap (F_BRANCH_FULL) > addr (F_ADDR_ONLY).
REQ-019 An accepted F_SYNC packet SHALL clear the start, bmap and addr flags as well as its own flag.
REQ-020 An accepted F_BRANCH_FULL packet SHALL also clear the addr flag.
REQ-021 A request arriving while the packet is held in OFFER SHALL NOT alter the held format; it takes effect at the next choice.
REQ-022 The start flag SHALL be set by reset, so the first packet after reset is F_SYNC/SF_START.
REQ-023 resync counter: +1 per accepted non-F_SYNC packet; reset to 0 on acceptance of any F_SYNC packet; saturates at all-ones.
REQ-024 When resync_max_i != 0 and the counter reaches resync_max_i, the start flag SHALL be set, and resync_pend_o = start flag.
REQ-025 resync_max_i == 0 SHALL never set the start flag from the counter.
REQ-026 bmap_flush_o SHALL pulse for one cycle on the cycle after acceptance of an F_SYNC or F_BRANCH_FULL packet.
REQ-027 A request pulse coinciding with acceptance of a packet of the same kind SHALL remain pending and cause one further packet.
REQ-028 Acceptance SHALL take zero extra cycles: back-to-back packets with emit_ready_i held high.

Reset
REQ-029 rst_ni low SHALL immediately force: state IDLE, emit_valid_o=0, packet_format_o=2'b00, packet_subformat_o=2'b00, bmap_flush_o=0, counter=0, exc/bmap/addr flags=0, start flag=1, resync_pend_o=1.
REQ-030 Reset asserted while in OFFER SHALL drop the offer without acceptance; the next offer after release is F_SYNC/SF_START.

Verification
REQ-031 Release reset, emit_ready_i=1 -> cycle 1: valid=1, format 11/00; cycle 2: bmap_flush_o=1, valid=0.
REQ-032 emit_ready_i=0, pulse bmap_full_i, then exc_req_i 2 cycles later -> format 01 held until ready=1; then 11/01 offered.
REQ-033 Pulse exc_req_i and updiscon_req_i together -> only F_SYNC/SF_EXCEPTION emitted; addr flag cleared, no F_ADDR_ONLY.
REQ-034 resync_max_i=3, ready=1, updiscon pulses each IDLE cycle -> 3 F_ADDR_ONLY, then F_SYNC/SF_START, counter=0.
REQ-035 resync_max_i=0, 70000 accepted addr packets -> no forced F_SYNC; counter saturates at 16'hFFFF.
REQ-036 Assert rst_ni low mid-OFFER (ready=0, format 10) -> valid drops asynchronously; after release the first offer is 11/00.
